// File: rtl/eqn_sweep_ctrl.sv
// Self-test sequencer for the 3-input SOP equation circuit: sweeps every input
// vector, captures Y after a settle delay and grades the truth table against EXP_MASK.
module eqn_sweep_ctrl #(
   parameter int unsigned                N_IN     = 3,
   parameter int unsigned                SETTLE   = 2,
   parameter logic [(1 << N_IN) - 1 : 0] EXP_MASK = 'hE0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   output logic [N_IN-1:0]              vec_out,
   input  logic                         y_in,
   output logic                         busy,
   output logic                         done,
   output logic [(1 << N_IN) - 1 : 0]   result,
   output logic                         pass,
   output logic [N_IN-1:0]              fail_idx
);

   localparam int unsigned NV = 1 << N_IN;
   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NV-1:0]   result_q, result_d;
   logic            pass_q, pass_d;
   logic [N_IN-1:0] fail_idx_q, fail_idx_d;

   logic [NV-1:0]   sampled;
   logic [NV-1:0]   diff;
   logic [N_IN-1:0] first_fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         pass_q     <= 1'b0;
         fail_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         pass_q     <= pass_d;
         fail_idx_q <= fail_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      pass_d     = pass_q;
      fail_idx_d = fail_idx_q;

      // Grade the table as it will look once the current Y is folded in.
      sampled        = result_q;
      sampled[idx_q] = y_in;
      diff           = sampled ^ EXP_MASK;
      first_fail     = '0;
      for (int unsigned i = NV; i > 0; i--) begin
         if (diff[i-1]) first_fail = N_IN'(i - 1);
      end

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d    = WAIT;
               idx_d      = '0;
               cnt_d      = '0;
               result_d   = '0;
               pass_d     = 1'b0;
               fail_idx_d = '0;
            end
         end
         WAIT: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
               cnt_d    = '0;
               result_d = sampled;
               if (idx_q == N_IN'(NV - 1)) begin
                  state_d    = DONE;
                  pass_d     = (sampled == EXP_MASK);
                  fail_idx_d = first_fail;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign vec_out  = (state_q == WAIT) ? idx_q : '0;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign pass     = pass_q;
   assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_eqn_sweep_ctrl.sv
// Bench for eqn_sweep_ctrl: time-based sweep model with per-cycle compare,
// directed scenarios pinned by literals, then randomized start/abort traffic.
module tb_eqn_sweep_ctrl;

   localparam int         S   = 2;
   localparam int         NV  = 8;
   localparam logic [7:0] EXP = 8'hE0;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [2:0] vec_out, fail_idx, vec1, fail1;
   logic       y_in, busy, done, pass, y1, busy1, done1, pass1;
   logic [7:0] result, result1;
   logic [7:0] rtab = 8'h5A;
   int         mode = 0;
   int         n_vec = 0, n_err = 0;
   bit         cmp_en = 1'b0;

   always #5 clk = ~clk;

   // 0: golden ABC+AB+AC, 1: stuck-at-0, 2: A&B only, 3: arbitrary table
   function automatic logic yf(input int md, input logic [2:0] v, input logic [7:0] tab);
      logic a, b, c;
      {a, b, c} = v;
      case (md)
         0:       return (a & b & c) | (a & b) | (a & c);
         1:       return 1'b0;
         2:       return a & b;
         default: return tab[v];
      endcase
   endfunction

   function automatic logic [2:0] lowest(input logic [7:0] d);
      logic [2:0] r = 3'd0;
      for (int i = 7; i >= 0; i--) if (d[i]) r = i[2:0];
      return r;
   endfunction

   assign y_in = yf(mode, vec_out, rtab);
   assign y1   = yf(0, vec1, rtab);

   eqn_sweep_ctrl #(.N_IN(3), .SETTLE(S), .EXP_MASK(EXP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_out(vec_out),
      .y_in(y_in), .busy(busy), .done(done), .result(result), .pass(pass),
      .fail_idx(fail_idx));

   eqn_sweep_ctrl #(.N_IN(3), .SETTLE(1), .EXP_MASK(EXP)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .vec_out(vec1),
      .y_in(y1), .busy(busy1), .done(done1), .result(result1), .pass(pass1),
      .fail_idx(fail1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 sweeping (m_t cycles since accept), 2 done cycle.
   int         m_ph, m_t;
   logic [7:0] m_res;
   logic       m_pass;
   logic [2:0] m_fail;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_t <= 0; m_res <= '0; m_pass <= 1'b0; m_fail <= '0;
      end else if (m_ph == 0) begin
         if (start && !abort) begin
            m_ph <= 1; m_t <= 0; m_res <= '0; m_pass <= 1'b0; m_fail <= '0;
         end
      end else if (m_ph == 1) begin
         if (abort) m_ph <= 0;
         else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % S == 0) begin
               m_res[(m_t + 1) / S - 1] <= yf(mode, 3'((m_t + 1) / S - 1), rtab);
               if (m_t + 1 == NV * S) begin
                  m_ph   <= 2;
                  m_pass <= ({yf(mode, 3'd7, rtab), m_res[6:0]} == EXP);
                  m_fail <= lowest({yf(mode, 3'd7, rtab), m_res[6:0]} ^ EXP);
               end
            end
         end
      end else begin
         m_ph <= 0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("vec_out",  vec_out,  (m_ph == 1) ? 32'(m_t / S) : 32'd0);
         chk("busy",     busy,     m_ph != 0);
         chk("done",     done,     m_ph == 2);
         chk("result",   result,   m_res);
         chk("pass",     pass,     m_pass);
         chk("fail_idx", fail_idx, m_fail);
      end
   end

   task automatic sweep(input int md, input bit repulse, output int lat);
      bit pulsed = 1'b0;
      mode  = md;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 100) begin
         if (repulse && !pulsed && vec_out == 3'd4) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end else start = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic wait_vec(input logic [2:0] v);
      int n = 0;
      while (vec_out != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_vec", vec_out, v);
   endtask

   initial begin
      int lat;
      #12 rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_vec", vec_out, 0);
      chk("rst_result", result, 0);
      chk("rst_pass", pass, 0);

      sweep(0, 1'b0, lat);
      chk("gold_lat", lat, 16);
      chk("gold_result", result, 8'hE0);
      chk("gold_pass", pass, 1);
      chk("gold_fidx", fail_idx, 0);
      @(negedge clk);
      chk("gold_busy_after", busy, 0);

      sweep(1, 1'b0, lat);
      chk("sa0_result", result, 8'h00);
      chk("sa0_pass", pass, 0);
      chk("sa0_fidx", fail_idx, 5);
      @(negedge clk);

      sweep(2, 1'b0, lat);
      chk("ab_result", result, 8'hC0);
      chk("ab_pass", pass, 0);
      chk("ab_fidx", fail_idx, 5);
      @(negedge clk);

      sweep(0, 1'b1, lat);
      chk("repulse_lat", lat, 16);
      chk("repulse_pass", pass, 1);
      @(negedge clk);

      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 100) begin
         if (lat < 8) chk("s1_vec", vec1, lat);
         @(negedge clk);
         lat++;
      end
      chk("s1_lat", lat, 8);
      chk("s1_result", result1, 8'hE0);
      chk("s1_pass", pass1, 1);

      mode  = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_vec(3'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_vec", vec_out, 0);
      chk("abort_result", result, 8'h00);
      repeat (2) @(negedge clk);
      sweep(0, 1'b0, lat);
      chk("post_abort_pass", pass, 1);
      @(negedge clk);

      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_vec(3'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vec", vec_out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_result", result, 0);
      chk("arst_pass", pass, 0);
      chk("arst_fidx", fail_idx, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sweep(0, 1'b0, lat);
      chk("post_rst_result", result, 8'hE0);

      repeat (1500) begin
         @(negedge clk);
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 39) == 0);
         if (m_ph == 0 && $urandom_range(0, 3) == 0) begin
            mode = $urandom_range(0, 3);
            rtab = 8'($urandom);
         end
      end
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eqn_sweep_ctrl.md
Name: eqn_sweep_ctrl

Overview:
Sequencer for the 3-input SOP equation circuit (Y = ABC + AB + AC). It drives the circuit inputs through every combination, waits a programmable settle time for gate delays, and captures Y into a truth-table register. On completion it compares that register against an expected mask and reports pass/fail, replacing the hand-written input sweep with a reusable self-test controller.

Parameters:
N_IN, 3, number of equation inputs; vector width; table has 2**N_IN entries
SETTLE, 2, clock cycles each vector is held before Y is sampled; legal range >= 1
EXP_MASK, 8'hE0, expected truth table (width 2**N_IN); bit i = expected Y for input vector i

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel an active sweep
vec_out  output  N_IN  drive to equation circuit inputs; MSB = A, LSB = C
y_in  input  1  equation circuit output Y
busy  output  1  high from the edge that accepts start until return to IDLE
done  output  1  one-cycle pulse when a sweep completes
result  output  2**N_IN  captured truth table; bit i = Y sampled for vector i
pass  output  1  result == EXP_MASK; valid from done, held until next start
fail_idx  output  N_IN  lowest i with result[i] != EXP_MASK[i]; 0 when pass

Behaviour:
- Reset (async, rst_n=0): state IDLE, vec_out=0, busy=0, done=0, result=0, pass=0, fail_idx=0, idx=0, cnt=0.
- States: IDLE, WAIT, DONE.
- IDLE: vec_out=0. start=1 and abort=0 -> WAIT; idx<=0, cnt<=0, vec_out<=0, result<=0, pass<=0, fail_idx<=0, busy<=1.
- WAIT: vec_out = idx. cnt increments each edge. On the edge where cnt==SETTLE-1, result[idx]<=y_in and cnt<=0.
  - If idx < 2**N_IN-1, then idx<=idx+1 and vec_out<=idx+1. The state stays WAIT.
  - Otherwise the next state is DONE. On that same edge, pass and fail_idx are computed from the final result value, including the bit just sampled.
- Each vector is held for exactly SETTLE cycles. Y is sampled at the last edge of that hold.
- DONE: done=1 for exactly one cycle and busy stays 1. The next edge goes to IDLE with busy<=0 and vec_out<=0.
- Latency: done is high in the cycle beginning 2**N_IN*SETTLE edges after the edge that accepted start. For defaults, that is 16 cycles.
- abort=1 in WAIT: next edge goes to IDLE with vec_out<=0 and busy<=0. No done pulse. result keeps partially captured bits. pass stays 0 and fail_idx stays 0.
- abort in DONE is ignored; completion stands.
- start and abort high together in IDLE: abort wins and the block stays IDLE.
- start while busy is ignored and does not restart the sweep.
- A new start after completion clears result, pass and fail_idx on the accepting edge.
- rst_n low mid-sweep: all outputs immediately take their reset values. No done pulse.
- Idx wraps never: the sweep terminates at 2**N_IN-1.
- fail_idx uses a priority search from bit 0 upward over result ^ EXP_MASK.
- The equation circuit's gate delays (2 levels x 1 time unit) must be shorter than SETTLE clock periods; the bench uses a clk period of 10 time units.

Test Plan:
- Golden circuit: connect the equation circuit and pulse start for 1 cycle. Required: vec_out steps 0..7, 2 cycles each; done pulses 16 cycles after start; result=8'hE0, pass=1, fail_idx=0; busy low the cycle after done.
- Faulty model: Y stuck-at-0. Required: result=8'h00, pass=0, fail_idx=5. Faulty model Y = A&B only: result=8'hC0, pass=0, fail_idx=5.
- SETTLE=1 override with the golden circuit: each vector is held 1 cycle; done 8 cycles after start; result=8'hE0, pass=1.
- Abort with vec_out=3: next cycle busy=0 and vec_out=0; no done pulse; result=8'h00 for the golden circuit, since vectors 0..2 sample 0. A fresh start then completes with pass=1.
- Start re-pulsed at vec_out=4 is ignored and done still arrives at cycle 16. Start and abort together in IDLE leave busy=0.
- rst_n low at vec_out=6: all outputs go to 0 asynchronously before the next edge. After release, start gives a full sweep with result=8'hE0.
